// File: rtl/ctrl_qmem_arb_if.sv
// qmem bus bundle: one master-to-slave link.
// The master drives request fields and the slave returns data, ack and err.
interface ctrl_qmem_arb_if #(
   parameter int QAW = 22,
   parameter int QDW = 32,
   parameter int QSW = QDW/8
);
   logic [QAW-1:0] adr;
   logic           cs;
   logic           we;
   logic [QSW-1:0] sel;
   logic [QDW-1:0] dat_w;
   logic [QDW-1:0] dat_r;
   logic           ack;
   logic           err;

   modport master (
      output adr, cs, we, sel, dat_w,
      input  dat_r, ack, err
   );

   modport slave (
      input  adr, cs, we, sel, dat_w,
      output dat_r, ack, err
   );
endinterface

// File: rtl/ctrl_qmem_arb.sv
// Round-robin two-master qmem arbiter for the control register slave.
// Grants are held across slave wait states; stuck transfers time out with ack+err.
module ctrl_qmem_arb #(
   parameter int QAW = 22,
   parameter int QDW = 32,
   parameter int QSW = QDW/8,
   parameter int TMO = 1023
) (
   input  logic             clk,
   input  logic             rst_n,
   ctrl_qmem_arb_if.slave   m0,
   ctrl_qmem_arb_if.slave   m1,
   ctrl_qmem_arb_if.master  s
);

   localparam logic [9:0] TMO_C = 10'(TMO);

   logic       lock;
   logic       own;
   logic       last;
   logic [9:0] tmo_cnt;

   logic           gnt;
   logic           gnt_v;
   logic           g_cs;
   logic           act;
   logic           tmo_hit;
   logic           done;
   logic [QAW-1:0] adr_g;
   logic [QSW-1:0] sel_g;
   logic [QDW-1:0] dat_g;
   logic           we_g;

   always_comb begin
      gnt   = 1'b0;
      gnt_v = 1'b1;
      if (lock)
         gnt = own;
      else if (m0.cs && m1.cs)
         gnt = ~last;
      else if (m0.cs)
         gnt = 1'b0;
      else if (m1.cs)
         gnt = 1'b1;
      else
         gnt_v = 1'b0;
   end

   assign g_cs  = gnt ? m1.cs    : m0.cs;
   assign adr_g = gnt ? m1.adr   : m0.adr;
   assign sel_g = gnt ? m1.sel   : m0.sel;
   assign dat_g = gnt ? m1.dat_w : m0.dat_w;
   assign we_g  = gnt ? m1.we    : m0.we;

   assign act = gnt_v & g_cs;

   // A real ack in the expiry cycle wins over the forced termination.
   assign tmo_hit = lock & act & ~s.ack & (tmo_cnt == TMO_C);
   assign done    = act & (s.ack | tmo_hit);

   assign s.cs    = act & ~tmo_hit;
   assign s.adr   = act ? adr_g : '0;
   assign s.sel   = act ? sel_g : '0;
   assign s.we    = act & we_g;
   assign s.dat_w = dat_g;

   assign m0.ack   = done & ~gnt;
   assign m1.ack   = done & gnt;
   assign m0.err   = act & ~gnt & (s.err | tmo_hit);
   assign m1.err   = act & gnt & (s.err | tmo_hit);
   assign m0.dat_r = s.dat_r;
   assign m1.dat_r = s.dat_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock    <= 1'b0;
         own     <= 1'b0;
         last    <= 1'b1;
         tmo_cnt <= '0;
      end else if (!lock) begin
         if (act) begin
            if (s.ack) begin
               last <= gnt;
            end else begin
               lock    <= 1'b1;
               own     <= gnt;
               tmo_cnt <= '0;
            end
         end
      end else if (!g_cs) begin
         // Owner abandoned the transfer: release without touching fairness.
         lock    <= 1'b0;
         tmo_cnt <= '0;
      end else if (s.ack || tmo_hit) begin
         lock    <= 1'b0;
         last    <= own;
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 10'd1;
      end
   end

endmodule

// File: tb/tb_ctrl_qmem_arb.sv
// Directed bench for ctrl_qmem_arb: ties, wait states, timeout, async reset.
module tb_ctrl_qmem_arb;

   localparam logic [21:0] A0 = 22'h000010;
   localparam logic [21:0] A1 = 22'h000204;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   int   early;

   ctrl_qmem_arb_if #(.QAW(22), .QDW(32)) m0_if ();
   ctrl_qmem_arb_if #(.QAW(22), .QDW(32)) m1_if ();
   ctrl_qmem_arb_if #(.QAW(22), .QDW(32)) s_if ();

   ctrl_qmem_arb dut (
      .clk   (clk),
      .rst_n (rst_n),
      .m0    (m0_if),
      .m1    (m1_if),
      .s     (s_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      m0_if.adr    = A0;
      m0_if.cs     = 1'b0;
      m0_if.we     = 1'b0;
      m0_if.sel    = 4'hf;
      m0_if.dat_w  = 32'h0;
      m1_if.adr    = A1;
      m1_if.cs     = 1'b0;
      m1_if.we     = 1'b0;
      m1_if.sel    = 4'h3;
      m1_if.dat_w  = 32'h0;
      s_if.dat_r   = 32'hdeadbeef;
      s_if.ack     = 1'b0;
      s_if.err     = 1'b0;

      #3;
      chk("rst_s_cs", s_if.cs, 0);
      chk("rst_s_adr", s_if.adr, 0);
      chk("rst_m0_ack", m0_if.ack, 0);
      chk("rst_m1_ack", m1_if.ack, 0);
      chk("rst_m0_err", m0_if.err, 0);
      tick();
      rst_n = 1'b1;

      // tie after reset alternates 0,1,0,1
      m0_if.cs = 1'b1;
      m1_if.cs = 1'b1;
      s_if.ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("tie_adr", s_if.adr, (i % 2) ? A1 : A0);
         chk("tie_m0_ack", m0_if.ack, (i % 2) ? 0 : 1);
         chk("tie_m1_ack", m1_if.ack, (i % 2) ? 1 : 0);
         tick();
      end
      m0_if.cs = 1'b0;
      m1_if.cs = 1'b0;

      // single-cycle m0 read
      m0_if.cs = 1'b1;
      @(negedge clk);
      chk("single_s_cs", s_if.cs, 1);
      chk("single_m0_ack", m0_if.ack, 1);
      chk("single_m1_ack", m1_if.ack, 0);
      chk("single_bcast", m1_if.dat_r, 32'hdeadbeef);
      tick();
      m0_if.cs = 1'b0;
      s_if.ack = 1'b0;
      @(negedge clk);
      chk("single_nolock_cs", s_if.cs, 0);
      chk("single_idle_ack", m0_if.ack, 0);
      tick();

      // last=0 now, so a tie goes to m1; then m0 with slave error
      m0_if.cs = 1'b1;
      m1_if.cs = 1'b1;
      s_if.ack = 1'b1;
      @(negedge clk);
      chk("last0_tie_adr", s_if.adr, A1);
      tick();
      s_if.err = 1'b1;
      @(negedge clk);
      chk("err_m0", m0_if.err, 1);
      chk("err_m1", m1_if.err, 0);
      tick();
      m0_if.cs = 1'b0;
      m1_if.cs = 1'b0;
      s_if.ack = 1'b0;
      s_if.err = 1'b0;
      tick();

      // m1 write with five wait states, m0 arrives at cycle 2
      m1_if.cs    = 1'b1;
      m1_if.we    = 1'b1;
      m1_if.dat_w = 32'h55;
      for (int c = 0; c < 6; c++) begin
         if (c == 2) m0_if.cs = 1'b1;
         if (c == 5) s_if.ack = 1'b1;
         @(negedge clk);
         chk("ws_adr", s_if.adr, A1);
         chk("ws_we", s_if.we, 1);
         chk("ws_m1_ack", m1_if.ack, (c == 5) ? 1 : 0);
         chk("ws_m0_ack", m0_if.ack, 0);
         tick();
      end
      m1_if.cs = 1'b0;
      m1_if.we = 1'b0;
      @(negedge clk);
      chk("ws_next_adr", s_if.adr, A0);
      chk("ws_next_ack", m0_if.ack, 1);
      chk("ws_next_cs", s_if.cs, 1);
      tick();
      m0_if.cs = 1'b0;
      s_if.ack = 1'b0;
      tick();

      // timeout: m0 stuck, m1 waiting from cycle 10
      early = 0;
      m0_if.cs = 1'b1;
      for (int c = 0; c < 1024; c++) begin
         if (c == 10) m1_if.cs = 1'b1;
         @(negedge clk);
         if (m0_if.ack || m0_if.err || m1_if.ack || !s_if.cs ||
             s_if.adr != A0)
            early++;
         tick();
      end
      @(negedge clk);
      chk("tmo_early", early, 0);
      chk("tmo_ack", m0_if.ack, 1);
      chk("tmo_err", m0_if.err, 1);
      chk("tmo_s_cs", s_if.cs, 0);
      chk("tmo_m1_ack", m1_if.ack, 0);
      tick();
      s_if.ack = 1'b1;
      @(negedge clk);
      chk("tmo_next_adr", s_if.adr, A1);
      chk("tmo_next_m1_ack", m1_if.ack, 1);
      chk("tmo_next_m0_ack", m0_if.ack, 0);
      tick();
      m0_if.cs = 1'b0;
      m1_if.cs = 1'b0;
      s_if.ack = 1'b0;
      tick();

      // real ack lands exactly on the expiry cycle
      early = 0;
      m0_if.cs = 1'b1;
      for (int c = 0; c < 1024; c++) begin
         @(negedge clk);
         if (m0_if.ack || m0_if.err || !s_if.cs) early++;
         tick();
      end
      s_if.ack = 1'b1;
      @(negedge clk);
      chk("bnd_early", early, 0);
      chk("bnd_ack", m0_if.ack, 1);
      chk("bnd_err", m0_if.err, 0);
      chk("bnd_s_cs", s_if.cs, 1);
      tick();
      m0_if.cs = 1'b0;
      s_if.ack = 1'b0;
      @(negedge clk);
      chk("bnd_idle_cs", s_if.cs, 0);
      tick();

      // async reset while m1 is locked in a wait state
      m1_if.cs = 1'b1;
      tick();
      tick();
      m0_if.cs = 1'b1;
      @(negedge clk);
      chk("ar_locked_adr", s_if.adr, A1);
      chk("ar_locked_m0_ack", m0_if.ack, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_adr", s_if.adr, A0);
      chk("ar_s_cs", s_if.cs, 1);
      chk("ar_m1_ack", m1_if.ack, 0);
      tick();
      rst_n = 1'b1;
      s_if.ack = 1'b1;
      @(negedge clk);
      chk("ar_tie_adr", s_if.adr, A0);
      chk("ar_tie_m0_ack", m0_if.ack, 1);
      tick();
      @(negedge clk);
      chk("ar_alt_adr", s_if.adr, A1);
      chk("ar_alt_m1_ack", m1_if.ack, 1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
